// File: rtl/jpeb_io_pkg.sv
// Shared I/O definitions: transmit scheduler FSM encoding and ASCII control bytes.
package jpeb_io_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Guard against misuse so pointers and count can never desynchronise.
  assign push_ok_c = push & ~full;
  assign pop_ok_c  = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok_c) - CW'(pop_ok_c);
    end
  end

  // Storage carries no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_tx_sched.sv
// Queues MMIO byte writes and issues them one at a time to the UART serializer.
// Optional build macro UART_TX_CRLF_EN expands each LF into a CR, LF pair on the line.
module uart_tx_sched
  import jpeb_io_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     ovf_clr,
  input  logic                     tx_busy,
  output logic                     tx_en,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     idle
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_inc_c;
  logic              timeout_c;
  logic [BYTE_W-1:0] head;
  logic              push_c;
  logic              pop_c;
  logic              insert_cr_c;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (wr_data),
    .pop       (pop_c),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  // Full is taken from the registered count, so a same-cycle pop cannot rescue a write.
  assign push_c = wr_en & ~full;

`ifdef UART_TX_CRLF_EN
  logic cr_sent;

  // First ISSUE of an LF head sends CR without popping; the second sends the LF itself.
  assign insert_cr_c = (head == ASCII_LF) & ~cr_sent;

  always_ff @(posedge clk) begin
    if (reset)                  cr_sent <= 1'b0;
    else if (state == ST_ISSUE) cr_sent <= insert_cr_c;
  end
`else
  assign insert_cr_c = 1'b0;
`endif

  assign timer_inc_c = timer + TW'(1);
  assign timeout_c   = (timer_inc_c == TW'(ACK_TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (count != '0) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)        state_nxt = ST_WAIT_DONE;
        else if (timeout_c) state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    tx_en = 1'b0;
    pop_c = 1'b0;
    idle  = 1'b0;
    case (state)
      ST_IDLE:  idle = (count == '0);
      ST_ISSUE: begin
        tx_en = 1'b1;
        pop_c = ~insert_cr_c;
      end
      default: ;
    endcase
  end

  // Ack timer counts WAIT_BUSY cycles since the last issue.
  always_ff @(posedge clk) begin
    if (reset)                      timer <= '0;
    else if (state == ST_ISSUE)     timer <= '0;
    else if (state == ST_WAIT_BUSY) timer <= timer_inc_c;
  end

  // Byte is latched on entry to ISSUE and held afterwards.
  always_ff @(posedge clk) begin
    if (reset)
      tx_data <= '0;
    else if (state == ST_IDLE && state_nxt == ST_ISSUE)
      tx_data <= insert_cr_c ? ASCII_CR : head;
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)              overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (DEPTH=16, ACK_TIMEOUT=15).
module tb_uart_tx_sched;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       ovf_clr  = 1'b0;
  logic       tx_busy  = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       idle;

  int vectors    = 0;
  int miscompares = 0;

  uart_tx_sched #(.DEPTH(16), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; tx_busy = 1'b0;
    tick; tick;
    reset = 1'b0;
    vectors++; if (tx_en !== 1'b0)    begin miscompares++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    vectors++; if (full !== 1'b0)     begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (count !== 5'd0)    begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (idle !== 1'b1)     begin miscompares++; $display("FAIL reset_idle got %b want 1", idle); end
  endtask

  task automatic test_basic;
    wr_en = 1'b1; wr_data = 8'h41;
    tick;
    wr_en = 1'b0;
    vectors++; if (count !== 5'd1)  begin miscompares++; $display("FAIL basic_count_n1 got %0d want 1", count); end
    vectors++; if (tx_en !== 1'b0)  begin miscompares++; $display("FAIL basic_tx_en_n1 got %b want 0", tx_en); end
    tick;
    vectors++; if (tx_en !== 1'b1)    begin miscompares++; $display("FAIL basic_tx_en_n2 got %b want 1", tx_en); end
    vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL basic_tx_data_n2 got %h want 41", tx_data); end
    tick;
    vectors++; if (tx_en !== 1'b0)    begin miscompares++; $display("FAIL basic_tx_en_n3 got %b want 0", tx_en); end
    vectors++; if (count !== 5'd0)    begin miscompares++; $display("FAIL basic_count_n3 got %0d want 0", count); end
    vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL basic_tx_data_hold got %h want 41", tx_data); end
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      vectors++; if (idle !== 1'b0 || tx_en !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle cyc %0d idle %b tx_en %b want 0 0", i, idle, tx_en); end
    end
    tx_busy = 1'b0;
    tick;
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL basic_idle_after_busy got %b want 1", idle); end
  endtask

  task automatic test_overflow;
    // Park the FSM in WAIT_DONE so nothing drains while filling.
    tx_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h00;
    tick;
    wr_en = 1'b0;
    tick; tick; tick;
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL ovf_parked_count got %0d want 0", count); end
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      if (i == 16) begin
        vectors++; if (full !== 1'b1 || count !== 5'd16) begin miscompares++; $display("FAIL ovf_full_at_17th full %b count %0d want 1 16", full, count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_not_yet got %b want 0", overflow); end
      end
      tick;
    end
    wr_en = 1'b0;
    vectors++; if (full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full got %b want 1", full); end
    vectors++; if (count !== 5'd16)   begin miscompares++; $display("FAIL ovf_count got %0d want 16", count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", overflow); end
    wr_en = 1'b1; wr_data = 8'h77; ovf_clr = 1'b1;
    tick;
    wr_en = 1'b0; ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    vectors++; if (count !== 5'd16)   begin miscompares++; $display("FAIL ovf_count_after_drop got %0d want 16", count); end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr2 got %b want 0", overflow); end
  endtask

  task automatic test_full_pop;
    int early;
    tx_busy = 1'b0;
    tick;
    vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL fp_idle_tx_en got %b want 0", tx_en); end
    tick;
    vectors++; if (tx_en !== 1'b1 || tx_data !== 8'h10) begin miscompares++; $display("FAIL fp_issue tx_en %b data %h want 1 10", tx_en, tx_data); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fp_full_at_issue got %b want 1", full); end
    wr_en = 1'b1; wr_data = 8'hEE;
    tick;
    wr_en = 1'b0;
    vectors++; if (count !== 5'd15)   begin miscompares++; $display("FAIL fp_count got %0d want 15", count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fp_overflow got %b want 1", overflow); end
    vectors++; if (full !== 1'b0)     begin miscompares++; $display("FAIL fp_full_after got %b want 0", full); end
    early = 0;
    for (int i = 0; i < 15; i++) begin
      if (tx_en) early++;
      tick;
    end
    vectors++; if (early != 0 || tx_en !== 1'b0 || idle !== 1'b0) begin miscompares++; $display("FAIL fp_timeout_gap early %0d tx_en %b idle %b want 0 0 0", early, tx_en, idle); end
    tick;
    vectors++; if (tx_en !== 1'b1 || tx_data !== 8'h11) begin miscompares++; $display("FAIL fp_next_issue tx_en %b data %h want 1 11", tx_en, tx_data); end
  endtask

  task automatic test_timeout;
    int pulses;
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55;
    tick;
    wr_en = 1'b0;
    tick;
    vectors++; if (tx_en !== 1'b1 || tx_data !== 8'h55) begin miscompares++; $display("FAIL to_issue tx_en %b data %h want 1 55", tx_en, tx_data); end
    pulses = 1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      if (tx_en) pulses++;
      if (k == 15) begin
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL to_idle_k15 got %b want 0", idle); end
      end
      if (k == 16) begin
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL to_idle_k16 got %b want 1", idle); end
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick;
      if (tx_en) pulses++;
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL to_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_crlf;
    logic [7:0] seen_d [4];
    logic [4:0] seen_c [4];
    logic [7:0] exp_d  [3];
    logic [4:0] exp_c  [3];
    int n_iss, exp_n, viol;
    logic prev_en;
`ifdef UART_TX_CRLF_EN
    exp_n = 3;
    exp_d[0] = 8'h48; exp_d[1] = 8'h0D; exp_d[2] = 8'h0A;
    exp_c[0] = 5'd2;  exp_c[1] = 5'd1;  exp_c[2] = 5'd1;
`else
    exp_n = 2;
    exp_d[0] = 8'h48; exp_d[1] = 8'h0A; exp_d[2] = 8'h00;
    exp_c[0] = 5'd2;  exp_c[1] = 5'd1;  exp_c[2] = 5'd0;
`endif
    for (int i = 0; i < 4; i++) begin seen_d[i] = 8'h00; seen_c[i] = 5'd0; end
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h48;
    tick;
    wr_data = 8'h0A;
    tick;
    wr_en = 1'b0;
    n_iss = 0; viol = 0; prev_en = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (tx_en) begin
        if (n_iss < 4) begin seen_d[n_iss] = tx_data; seen_c[n_iss] = count; end
        n_iss++;
      end
      if (tx_en && prev_en) viol++;
      prev_en = tx_en;
      tick;
    end
    vectors++; if (n_iss != exp_n) begin miscompares++; $display("FAIL crlf_issue_count got %0d want %0d", n_iss, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      vectors++; if (seen_d[i] !== exp_d[i]) begin miscompares++; $display("FAIL crlf_byte%0d got %h want %h", i, seen_d[i], exp_d[i]); end
      vectors++; if (seen_c[i] !== exp_c[i]) begin miscompares++; $display("FAIL crlf_count%0d got %0d want %0d", i, seen_c[i], exp_c[i]); end
    end
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL crlf_back_to_back_tx_en got %0d want 0", viol); end
    vectors++; if (count !== 5'd0 || idle !== 1'b1) begin miscompares++; $display("FAIL crlf_drained count %0d idle %b want 0 1", count, idle); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick;
    end
    wr_en = 1'b0;
    vectors++; if (count !== 5'd3 || idle !== 1'b0) begin miscompares++; $display("FAIL rm_before count %0d idle %b want 3 0", count, idle); end
    reset = 1'b1;
    tick;
    reset = 1'b0; tx_busy = 1'b0;
    vectors++; if (count !== 5'd0)  begin miscompares++; $display("FAIL rm_count got %0d want 0", count); end
    vectors++; if (idle !== 1'b1)   begin miscompares++; $display("FAIL rm_idle got %b want 1", idle); end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_en) pulses++;
      tick;
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rm_no_tx_en got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_full_pop;
    test_reset;
    test_timeout;
    test_reset;
    test_crlf;
    test_reset;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
